// File: rtl/board_engine_nxn.sv
// SIZE x SIZE 2048 board engine. It slides/merges one line per cycle, spawns tiles
// from an internal LFSR, keeps a saturating score and reports win/lose.
module board_engine_nxn #(
    parameter int unsigned SIZE    = 4,
    parameter int unsigned TILE_W  = 4,
    parameter int unsigned WIN_EXP = 11,
    parameter int unsigned SCORE_W = 20,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic                        clock,
    input  logic                        start,
    input  logic [3:0]                  direction,
    input  logic                        load,
    input  logic [SIZE*SIZE*TILE_W-1:0] load_board,
    output logic [SIZE*SIZE*TILE_W-1:0] board,
    output logic [SCORE_W-1:0]          score,
    output logic                        busy,
    output logic                        moved,
    output logic                        move_done,
    output logic [1:0]                  endstatus
);
    localparam int unsigned N     = SIZE * SIZE;
    localparam int unsigned CellW = $clog2(N);
    localparam int unsigned LineW = $clog2(SIZE);
    localparam logic [CellW:0]    NCells  = (CellW + 1)'(N);
    localparam logic [TILE_W-1:0] TileMax = '1;

    typedef enum logic [2:0] {StInit, StIdle, StShift, StSpawn, StCheck} state_e;

    state_e             state_q, state_d;
    logic [TILE_W-1:0]  cell_q [N];
    logic [TILE_W-1:0]  cell_d [N];
    logic [SCORE_W-1:0] score_q, score_d;
    logic               moved_q, moved_d;
    logic               done_q, done_d;
    logic [1:0]         end_q, end_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [3:0]         dir_prev_q;
    logic [3:0]         dir_q, dir_d;
    logic [LineW-1:0]   line_q, line_d;
    logic [CellW-1:0]   spawn_idx_q, spawn_idx_d;
    logic [CellW-1:0]   spawn_cnt_q, spawn_cnt_d;
    logic               spawn_two_q, spawn_two_d;

    logic [CellW-1:0]   line_pos [SIZE];
    logic [TILE_W-1:0]  line_in  [SIZE];
    logic [TILE_W-1:0]  line_out [SIZE];
    logic [TILE_W-1:0]  comp     [SIZE+1];
    logic [TILE_W-1:0]  merged;
    logic [SCORE_W-1:0] line_score;
    logic               line_changed;
    logic               skip;
    int unsigned        cnt;

    logic [CellW-1:0]   spawn_start, spawn_pos, spawn_next;
    logic               spawn_free;
    logic               won, has_empty, has_pair;
    logic               accept;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
    endfunction

    function automatic logic [SCORE_W-1:0] tile_value(input logic [TILE_W-1:0] e);
        logic [SCORE_W-1:0] v;
        if (32'(e) >= SCORE_W) v = '1;
        else v = SCORE_W'(1) << e;
        return v;
    endfunction

    // Position p counts from the leading edge of line j for the latched direction.
    function automatic logic [CellW-1:0] cell_index(input logic [3:0] d,
                                                    input logic [LineW-1:0] j,
                                                    input int unsigned p);
        int unsigned r, c;
        if (d[3]) begin
            r = p;
            c = 32'(j);
        end else if (d[2]) begin
            r = SIZE - 1 - p;
            c = 32'(j);
        end else if (d[1]) begin
            r = 32'(j);
            c = p;
        end else begin
            r = 32'(j);
            c = SIZE - 1 - p;
        end
        return CellW'(r * SIZE + c);
    endfunction

    // Line operation: compact toward the leading edge, then merge pairs once each.
    always_comb begin
        for (int unsigned p = 0; p < SIZE; p++) begin
            line_pos[p] = cell_index(dir_q, line_q, p);
            line_in[p]  = cell_q[line_pos[p]];
            line_out[p] = '0;
        end
        for (int unsigned p = 0; p <= SIZE; p++) comp[p] = '0;
        cnt = 0;
        for (int unsigned p = 0; p < SIZE; p++) begin
            if (line_in[p] != '0) begin
                for (int unsigned o = 0; o < SIZE; o++) begin
                    if (o == cnt) comp[o] = line_in[p];
                end
                cnt = cnt + 1;
            end
        end
        skip       = 1'b0;
        merged     = '0;
        line_score = '0;
        cnt        = 0;
        for (int unsigned p = 0; p < SIZE; p++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (comp[p] != '0) begin
                if (comp[p+1] == comp[p]) begin
                    merged     = (comp[p] == TileMax) ? TileMax : comp[p] + TILE_W'(1);
                    skip       = 1'b1;
                    line_score = sat_add(line_score, tile_value(merged));
                end else begin
                    merged = comp[p];
                end
                for (int unsigned o = 0; o < SIZE; o++) begin
                    if (o == cnt) line_out[o] = merged;
                end
                cnt = cnt + 1;
            end
        end
        line_changed = 1'b0;
        for (int unsigned p = 0; p < SIZE; p++) begin
            if (line_out[p] != line_in[p]) line_changed = 1'b1;
        end
    end

    always_comb begin
        spawn_start = lfsr_q[CellW-1:0];
        if ({1'b0, spawn_start} >= NCells) spawn_start = spawn_start - NCells[CellW-1:0];
        spawn_pos  = (spawn_cnt_q == '0) ? spawn_start : spawn_idx_q;
        spawn_next = (spawn_pos == CellW'(N - 1)) ? '0 : spawn_pos + CellW'(1);
        spawn_free = (cell_q[spawn_pos] == '0);
    end

    always_comb begin
        won       = 1'b0;
        has_empty = 1'b0;
        has_pair  = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (32'(cell_q[i]) >= WIN_EXP) won = 1'b1;
            if (cell_q[i] == '0) has_empty = 1'b1;
        end
        for (int unsigned r = 0; r < SIZE; r++) begin
            for (int unsigned c = 0; c + 1 < SIZE; c++) begin
                if (cell_q[r*SIZE+c] == cell_q[r*SIZE+c+1]) has_pair = 1'b1;
            end
        end
        for (int unsigned r = 0; r + 1 < SIZE; r++) begin
            for (int unsigned c = 0; c < SIZE; c++) begin
                if (cell_q[r*SIZE+c] == cell_q[(r+1)*SIZE+c]) has_pair = 1'b1;
            end
        end
    end

    // A held key yields one move: require an idle direction on the previous cycle.
    assign accept = (state_q == StIdle) && $onehot(direction) && (dir_prev_q == 4'd0) &&
                    (end_q == 2'b00);

    always_comb begin
        state_d     = state_q;
        cell_d      = cell_q;
        score_d     = score_q;
        moved_d     = moved_q;
        done_d      = 1'b0;
        end_d       = end_q;
        lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        dir_d       = dir_q;
        line_d      = line_q;
        spawn_idx_d = spawn_idx_q;
        spawn_cnt_d = spawn_cnt_q;
        spawn_two_d = spawn_two_q;
        case (state_q)
            StInit: begin
                spawn_two_d = 1'b1;
                spawn_cnt_d = '0;
                state_d     = StSpawn;
            end
            StIdle: begin
                if (load) begin
                    for (int unsigned i = 0; i < N; i++) begin
                        cell_d[i] = load_board[(N-i)*TILE_W-1 -: TILE_W];
                    end
                    end_d   = 2'b00;
                    state_d = StCheck;
                end else if (accept) begin
                    dir_d   = direction;
                    line_d  = '0;
                    moved_d = 1'b0;
                    state_d = StShift;
                end
            end
            StShift: begin
                for (int unsigned p = 0; p < SIZE; p++) cell_d[line_pos[p]] = line_out[p];
                score_d = sat_add(score_q, line_score);
                moved_d = moved_q | line_changed;
                if (line_q == LineW'(SIZE - 1)) begin
                    if (moved_q | line_changed) begin
                        spawn_cnt_d = '0;
                        spawn_two_d = 1'b0;
                        state_d     = StSpawn;
                    end else begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    line_d = line_q + LineW'(1);
                end
            end
            StSpawn: begin
                if (spawn_free) begin
                    cell_d[spawn_pos] = (lfsr_q[7:4] == 4'd0) ? TILE_W'(2) : TILE_W'(1);
                end
                if (spawn_free || spawn_cnt_q == CellW'(N - 1)) begin
                    spawn_cnt_d = '0;
                    spawn_two_d = 1'b0;
                    state_d     = spawn_two_q ? StSpawn : StCheck;
                end else begin
                    spawn_idx_d = spawn_next;
                    spawn_cnt_d = spawn_cnt_q + CellW'(1);
                end
            end
            StCheck: begin
                if (end_q == 2'b00) begin
                    if (won) end_d = 2'b01;
                    else if (!has_empty && !has_pair) end_d = 2'b10;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clock) begin
        if (start) begin
            state_q     <= StInit;
            for (int unsigned i = 0; i < N; i++) cell_q[i] <= '0;
            score_q     <= '0;
            moved_q     <= 1'b0;
            done_q      <= 1'b0;
            end_q       <= 2'b00;
            lfsr_q      <= SEED;
            dir_prev_q  <= 4'd0;
            dir_q       <= 4'd0;
            line_q      <= '0;
            spawn_idx_q <= '0;
            spawn_cnt_q <= '0;
            spawn_two_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cell_q      <= cell_d;
            score_q     <= score_d;
            moved_q     <= moved_d;
            done_q      <= done_d;
            end_q       <= end_d;
            lfsr_q      <= lfsr_d;
            dir_prev_q  <= direction;
            dir_q       <= dir_d;
            line_q      <= line_d;
            spawn_idx_q <= spawn_idx_d;
            spawn_cnt_q <= spawn_cnt_d;
            spawn_two_q <= spawn_two_d;
        end
    end

    always_comb begin
        board = '0;
        for (int unsigned i = 0; i < N; i++) board[(N-i)*TILE_W-1 -: TILE_W] = cell_q[i];
    end

    assign score     = score_q;
    assign busy      = (state_q != StIdle);
    assign moved     = moved_q;
    assign move_done = done_q;
    assign endstatus = end_q;

endmodule

// File: tb/tb_board_engine_nxn.sv
// Directed bench for board_engine_nxn at default parameters (4x4, 4-bit cells).
module tb_board_engine_nxn;
    logic        clock;
    logic        start;
    logic [3:0]  direction;
    logic        load;
    logic [63:0] load_board;
    logic [63:0] board;
    logic [19:0] score;
    logic        busy;
    logic        moved;
    logic        move_done;
    logic [1:0]  endstatus;

    int checks   = 0;
    int failures = 0;
    int n;
    int cnt;

    board_engine_nxn dut (
        .clock      (clock),
        .start      (start),
        .direction  (direction),
        .load       (load),
        .load_board (load_board),
        .board      (board),
        .score      (score),
        .busy       (busy),
        .moved      (moved),
        .move_done  (move_done),
        .endstatus  (endstatus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] cell_at(input int i);
        return board[(16-i)*4-1 -: 4];
    endfunction

    function automatic int count_nz(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) if (cell_at(i) != 4'd0) c++;
        return c;
    endfunction

    function automatic int sum_cells(input int lo, input int hi);
        int s = 0;
        for (int i = lo; i <= hi; i++) s += int'(cell_at(i));
        return s;
    endfunction

    function automatic int count_small(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) if (cell_at(i) == 4'd1 || cell_at(i) == 4'd2) c++;
        return c;
    endfunction

    task automatic wait_done(input int budget, output int ticks);
        ticks = 0;
        while (move_done !== 1'b1 && ticks < budget) begin
            tick();
            ticks++;
        end
    endtask

    task automatic do_load(input logic [63:0] img);
        int t;
        load       = 1'b1;
        load_board = img;
        tick();
        load = 1'b0;
        wait_done(4, t);
        chk("load_done", move_done, 1'b1);
    endtask

    task automatic press(input logic [3:0] d);
        direction = d;
        tick();
        direction = 4'd0;
    endtask

    initial begin
        start      = 1'b1;
        direction  = 4'd0;
        load       = 1'b0;
        load_board = '0;

        // Reset and INIT
        tick();
        chk("rst_board0", board, 64'h0);
        tick();
        tick();
        chk("rst_board2", board, 64'h0);
        chk("rst_score", score, 20'd0);
        chk("rst_end", endstatus, 2'b00);
        chk("rst_done", move_done, 1'b0);
        start = 1'b0;
        wait_done(34, n);
        chk("init_done", move_done, 1'b1);
        chk("init_busy", busy, 1'b0);
        chk("init_nz", count_nz(0, 15), 2);
        chk("init_vals", count_small(0, 15), 2);
        chk("init_score", score, 20'd0);
        chk("init_end", endstatus, 2'b00);

        // Merge [1,1,2,2] left -> [2,3,0,0], +12
        do_load(64'h1122_0000_0000_0000);
        chk("ld_board", board, 64'h1122_0000_0000_0000);
        chk("ld_score", score, 20'd0);
        press(4'b0010);
        chk("mv_busy", busy, 1'b1);
        wait_done(22, n);
        chk("m1_done", move_done, 1'b1);
        chk("m1_c0", cell_at(0), 4'd2);
        chk("m1_c1", cell_at(1), 4'd3);
        chk("m1_score", score, 20'd12);
        chk("m1_moved", moved, 1'b1);
        chk("m1_spawn_n", count_nz(2, 15), 1);
        chk("m1_spawn_v", (sum_cells(2, 15) == 1 || sum_cells(2, 15) == 2), 1'b1);

        // [1,1,1,1] left -> [2,2,0,0], +8
        do_load(64'h1111_0000_0000_0000);
        press(4'b0010);
        wait_done(22, n);
        chk("m2_row0lead", board[63:56], 8'h22);
        chk("m2_score", score, 20'd20);
        chk("m2_spawn_n", count_nz(2, 15), 1);

        // No-op left: unchanged, no spawn, done after SIZE shift cycles
        do_load(64'h1000_0000_0000_0000);
        press(4'b0010);
        wait_done(22, n);
        chk("nop_latency", n, 4);
        chk("nop_board", board, 64'h1000_0000_0000_0000);
        chk("nop_moved", moved, 1'b0);
        chk("nop_score", score, 20'd20);

        // Up on columns of equal tiles: rows 0,1 become [2,3,2,3], +48
        do_load(64'h1212_1212_1212_1212);
        press(4'b1000);
        wait_done(22, n);
        chk("up_rows01", board[63:32], 32'h2323_2323);
        chk("up_spawn_n", count_nz(8, 15), 1);
        chk("up_score", score, 20'd68);

        // Right on [3,0,3,3]: pair nearest col 3 merges -> [0,0,3,4], +16
        do_load(64'h3033_0000_0000_0000);
        press(4'b0001);
        wait_done(22, n);
        chk("rt_c2", cell_at(2), 4'd3);
        chk("rt_c3", cell_at(3), 4'd4);
        chk("rt_nz", count_nz(0, 15), 3);
        chk("rt_score", score, 20'd84);

        // Down on column 0 [1,0,0,1] -> cell 12 = 2, +4
        do_load(64'h1000_0000_0000_1000);
        press(4'b0100);
        wait_done(22, n);
        chk("dn_c12", cell_at(12), 4'd2);
        chk("dn_nz", count_nz(0, 15), 2);
        chk("dn_score", score, 20'd88);

        // Edge detect on a board where left is a no-op
        do_load(64'h1212_1212_1212_1212);
        chk("e_end", endstatus, 2'b00);
        direction = 4'b0010;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (move_done) cnt++;
        end
        chk("edge_held", cnt, 1);
        direction = 4'd0;
        tick();
        tick();
        direction = 4'b0010;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (move_done) cnt++;
        end
        chk("edge_second", cnt, 1);
        direction = 4'd0;
        tick();
        direction = 4'b0011;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy) cnt++;
        end
        chk("nonhot_busy", cnt, 0);
        direction = 4'd0;
        tick();
        chk("e_board", board, 64'h1212_1212_1212_1212);
        chk("e_score", score, 20'd88);

        // Win: [10,10] left -> 11, +2048, then moves ignored
        do_load(64'hAA00_0000_0000_0000);
        press(4'b0010);
        wait_done(22, n);
        chk("win_c0", cell_at(0), 4'd11);
        chk("win_score", score, 20'd2136);
        chk("win_end", endstatus, 2'b01);
        press(4'b0010);
        chk("win_ignored", busy, 1'b0);

        // Lose: full checkerboard of 1/2
        do_load(64'h1212_2121_1212_2121);
        chk("lose_end", endstatus, 2'b10);
        chk("lose_score", score, 20'd2136);

        // Reset mid-move at SHIFT cycle 2
        do_load(64'h1100_0000_0000_0000);
        chk("pre6_end", endstatus, 2'b00);
        press(4'b0010);
        tick();
        start = 1'b1;
        tick();
        chk("mid_board", board, 64'h0);
        chk("mid_score", score, 20'd0);
        chk("mid_busy", busy, 1'b1);
        chk("mid_moved", moved, 1'b0);
        tick();
        chk("mid_hold", board, 64'h0);
        start = 1'b0;
        wait_done(34, n);
        chk("re_done", move_done, 1'b1);
        chk("re_nz", count_nz(0, 15), 2);
        chk("re_vals", count_small(0, 15), 2);
        chk("re_score", score, 20'd0);
        chk("re_end", endstatus, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
